icache_fill_controller: RTL and testbench
=========================================

# icache_fill_controller

Sequences refills of the instruction cache. On a fill request for a 16-bit byte address, it reads one 32-byte block from the instruction memory port as a series of 64-bit beats and assembles the block. It then writes the block into the cache with a one-cycle write-enable pulse, driving the cache's writeEnable_i/writeAddress_i/writeBlock_i inputs. It sits between the fetch logic, which raises requests on a miss or at boot preload, and the backing memory.

## Interface
- BLOCK_SIZE, 32, bytes per cache block
- BITS_PER_BYTE, 8, bits per byte
- BEAT_BYTES, 8, bytes per memory beat; BEATS = BLOCK_SIZE/BEAT_BYTES = 4
- ADDR_WIDTH, 16, byte address width

Ports:
- clock_i  in  1  single clock, all state updates on rising edge
- reset_i  in  1  synchronous, active-high reset
- fillReq_i  in  1  request a block fill; sampled only when fillReady_o=1
- fillAddr_i  in  ADDR_WIDTH  any byte address inside the target block; low 5 bits ignored
- fillReady_o  out  1  high in IDLE; request accepted when fillReq_i & fillReady_o at an edge
- memReq_o  out  1  beat read request, held until acknowledged
- memAddr_o  out  ADDR_WIDTH  byte address of current beat = {block[15:5], beat[1:0], 3'b000}
- memAck_i  in  1  beat data valid on memData_i this cycle
- memData_i  in  BEAT_BYTES*BITS_PER_BYTE  beat data, byte 0 in bits [7:0]
- writeEnable_o  out  1  one-cycle cache write strobe
- writeAddress_o  out  ADDR_WIDTH  block-aligned write address (low 5 bits zero)
- writeBlock_o  out  BLOCK_SIZE*BITS_PER_BYTE  assembled block
- fillDone_o  out  1  one-cycle pulse, coincident with writeEnable_o
- fillCount_o  out  16  completed fills, wraps 0xFFFF->0x0000

## Operation
- States: IDLE, BEAT, WRITE. All outputs registered or decoded from state/registers only; no input-to-output combinational paths.
- IDLE: fillReady_o=1, memReq_o=0.
  - On fillReq_i: latch fillAddr_i[15:5] as blk, set beat=0, go to BEAT.
- BEAT: memReq_o=1, memAddr_o={blk,beat,3'b0}.
  - On memAck_i: write memData_i into buffer bits [64*beat+63 : 64*beat].
  - If beat=3, go to WRITE; otherwise beat++.
  - Without memAck_i, hold: no timeout, addresses stable.
- WRITE: writeEnable_o=1, fillDone_o=1, writeAddress_o={blk,5'b0}, writeBlock_o=buffer. fillCount_o increments at the end of this cycle. Next state is IDLE unconditionally.
- Buffer and writeAddress_o hold their last values after WRITE. writeBlock_o is only meaningful while writeEnable_o=1.
- memAck_i in IDLE or WRITE is ignored: no capture, no state change.
- fillReq_i outside IDLE is ignored and not queued. The requester must keep it high until accepted.
- Reset (any state, including mid-fill): state=IDLE, beat=0, buffer=0, writeAddress_o=0, fillCount_o=0, all strobes 0. An aborted fill produces no cache write.
- Reset outputs: fillReady_o=1, memReq_o=0, memAddr_o=0, writeEnable_o=0, writeAddress_o=0, writeBlock_o=0, fillDone_o=0, fillCount_o=0.

## Timing
- Request accepted at edge E0. memReq_o=1 with beat-0 address in the cycle after E0.
- With memAck_i high every cycle, beats are captured at E1..E4. writeEnable_o/fillDone_o are high in the cycle after E4, and fillReady_o=1 again the cycle after that.
- Minimum occupancy is 6 cycles per fill: accept-to-accept.
- Each memAck_i-low cycle adds exactly one cycle of latency.
- memReq_o drops in the cycle after the last-beat acknowledge.

## Test plan
- Reset then idle: all outputs at reset values, fillReady_o=1, 10 cycles with no activity.
- Back-to-back memory: fillAddr_i=0x1234, memory returns beat k=0x1111_1111_1111_1111*(k+1) with memAck_i=1 every cycle.
  - memAddr_o sequence 0x1220,0x1228,0x1230,0x1238.
  - writeAddress_o=0x1220; writeBlock_o[63:0]=0x1111..11 and [255:192]=0x4444..44.
  - Write occurs 5 cycles after accept; fillCount_o=1.
- Stalled memory: memAck_i low for 3 cycles before each beat.
  - memAddr_o holds for each beat until acknowledged.
  - The write occurs 17 cycles after accept, and the block matches.
- Ignored inputs: fillReq_i with 0x0040 during BEAT is not accepted and the original fill completes unchanged. Spurious memAck_i in IDLE leaves state and buffer unchanged.
- Reset mid-fill: reset_i after beat 2. No writeEnable_o occurs, fillCount_o=0, fillReady_o=1 the next cycle, and a new fill then completes correctly.
- Counter wrap: preload via 65536 fills (or a force), then confirm fillCount_o goes 0xFFFF -> 0x0000.

Source files
------------

// File: rtl/icache_fill_controller.sv
// Instruction-cache refill sequencer: fetches one 32-byte block as four
// 64-bit memory beats, assembles it, then writes it into the cache in one strobe.
module icache_fill_controller #(
  parameter int BLOCK_SIZE    = 32,
  parameter int BITS_PER_BYTE = 8,
  parameter int BEAT_BYTES    = 8,
  parameter int ADDR_WIDTH    = 16
) (
  input  logic                                clock_i,
  input  logic                                reset_i,
  input  logic                                fillReq_i,
  input  logic [ADDR_WIDTH-1:0]               fillAddr_i,
  output logic                                fillReady_o,
  output logic                                memReq_o,
  output logic [ADDR_WIDTH-1:0]               memAddr_o,
  input  logic                                memAck_i,
  input  logic [BEAT_BYTES*BITS_PER_BYTE-1:0] memData_i,
  output logic                                writeEnable_o,
  output logic [ADDR_WIDTH-1:0]               writeAddress_o,
  output logic [BLOCK_SIZE*BITS_PER_BYTE-1:0] writeBlock_o,
  output logic                                fillDone_o,
  output logic [15:0]                         fillCount_o
);

  localparam int BEATS      = BLOCK_SIZE / BEAT_BYTES;
  localparam int BEAT_W     = BEAT_BYTES * BITS_PER_BYTE;
  localparam int BLOCK_W    = BLOCK_SIZE * BITS_PER_BYTE;
  localparam int OFFSET_W   = $clog2(BLOCK_SIZE);
  localparam int BEAT_IDX_W = $clog2(BEATS);
  localparam int BYTE_OFF_W = $clog2(BEAT_BYTES);
  localparam int TAG_W      = ADDR_WIDTH - OFFSET_W;

  localparam logic [BEAT_IDX_W-1:0] LAST_BEAT = BEAT_IDX_W'(BEATS - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BEAT  = 2'd1,
    S_WRITE = 2'd2
  } state_t;

  state_t                  r_state;
  logic [TAG_W-1:0]        r_blk;
  logic [BEAT_IDX_W-1:0]   r_beat;
  logic [BLOCK_W-1:0]      r_buffer;
  logic [ADDR_WIDTH-1:0]   r_memAddr;
  logic [ADDR_WIDTH-1:0]   r_writeAddr;
  logic [15:0]             r_fillCount;
  logic                    r_fillReady;
  logic                    r_memReq;
  logic                    r_writeEnable;

  logic [TAG_W-1:0]        w_reqTag;
  logic [BEAT_IDX_W-1:0]   w_nextBeat;

  assign w_reqTag   = fillAddr_i[ADDR_WIDTH-1:OFFSET_W];
  assign w_nextBeat = r_beat + 1'b1;

  // Strobes and addresses are computed one edge ahead so every output is a flop.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      r_state       <= S_IDLE;
      r_blk         <= '0;
      r_beat        <= '0;
      r_buffer      <= '0;
      r_memAddr     <= '0;
      r_writeAddr   <= '0;
      r_fillCount   <= '0;
      r_fillReady   <= 1'b1;
      r_memReq      <= 1'b0;
      r_writeEnable <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (fillReq_i) begin
            r_blk       <= w_reqTag;
            r_beat      <= '0;
            r_memAddr   <= {w_reqTag, {BEAT_IDX_W{1'b0}}, {BYTE_OFF_W{1'b0}}};
            r_memReq    <= 1'b1;
            r_fillReady <= 1'b0;
            r_state     <= S_BEAT;
          end
        end
        S_BEAT: begin
          if (memAck_i) begin
            r_buffer[r_beat*BEAT_W +: BEAT_W] <= memData_i;
            if (r_beat == LAST_BEAT) begin
              r_memReq      <= 1'b0;
              r_writeEnable <= 1'b1;
              r_writeAddr   <= {r_blk, {OFFSET_W{1'b0}}};
              r_state       <= S_WRITE;
            end else begin
              r_beat    <= w_nextBeat;
              r_memAddr <= {r_blk, w_nextBeat, {BYTE_OFF_W{1'b0}}};
            end
          end
        end
        S_WRITE: begin
          r_writeEnable <= 1'b0;
          r_fillCount   <= r_fillCount + 1'b1;
          r_fillReady   <= 1'b1;
          r_state       <= S_IDLE;
        end
        default: begin
          r_state       <= S_IDLE;
          r_fillReady   <= 1'b1;
          r_memReq      <= 1'b0;
          r_writeEnable <= 1'b0;
        end
      endcase
    end
  end

  assign fillReady_o    = r_fillReady;
  assign memReq_o       = r_memReq;
  assign memAddr_o      = r_memAddr;
  assign writeEnable_o  = r_writeEnable;
  assign fillDone_o     = r_writeEnable;
  assign writeAddress_o = r_writeAddr;
  assign writeBlock_o   = r_buffer;
  assign fillCount_o    = r_fillCount;

endmodule

// File: tb/tb_icache_fill_controller.sv
// Self-checking bench for icache_fill_controller: a directed vector table,
// hand-written corner sequences and randomized fills against a block-level model.
module tb_icache_fill_controller;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          fillReq = 1'b0;
  logic [15:0]   fillAddr = '0;
  logic          fillReady;
  logic          memReq;
  logic [15:0]   memAddr;
  logic          memAck = 1'b0;
  logic [63:0]   memData = '0;
  logic          writeEnable;
  logic [15:0]   writeAddress;
  logic [255:0]  writeBlock;
  logic          fillDone;
  logic [15:0]   fillCount;

  int            testsRun = 0;
  int            testsFailed = 0;
  int            cyc = 0;
  logic [15:0]   expCount = '0;

  icache_fill_controller dut (
    .clock_i        (clock),
    .reset_i        (reset),
    .fillReq_i      (fillReq),
    .fillAddr_i     (fillAddr),
    .fillReady_o    (fillReady),
    .memReq_o       (memReq),
    .memAddr_o      (memAddr),
    .memAck_i       (memAck),
    .memData_i      (memData),
    .writeEnable_o  (writeEnable),
    .writeAddress_o (writeAddress),
    .writeBlock_o   (writeBlock),
    .fillDone_o     (fillDone),
    .fillCount_o    (fillCount)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic          req;
    logic [15:0]   addr;
    logic          ack;
    logic [63:0]   data;
    logic          expReady;
    logic          expMemReq;
    logic          chkAddr;
    logic [15:0]   expMemAddr;
    logic          expWe;
    logic [15:0]   expWaddr;
    logic [15:0]   expCount;
    logic          chkBlock;
  } vec_t;

  localparam logic [63:0] BEAT1 = 64'h1111_1111_1111_1111;
  localparam logic [255:0] B2B_BLOCK = {BEAT1 * 64'd4, BEAT1 * 64'd3, BEAT1 * 64'd2, BEAT1};

  vec_t vecs[8];

  function automatic vec_t mkVec(input logic req, input logic [15:0] addr, input logic ack,
                                 input logic [63:0] data, input logic eReady, input logic eMemReq,
                                 input logic cAddr, input logic [15:0] eMemAddr, input logic eWe,
                                 input logic [15:0] eWaddr, input logic [15:0] eCount,
                                 input logic cBlock);
    vec_t v;
    v.req = req; v.addr = addr; v.ack = ack; v.data = data;
    v.expReady = eReady; v.expMemReq = eMemReq; v.chkAddr = cAddr; v.expMemAddr = eMemAddr;
    v.expWe = eWe; v.expWaddr = eWaddr; v.expCount = eCount; v.chkBlock = cBlock;
    return v;
  endfunction

  // Outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clock);
    #1;
    cyc++;
  endtask

  task automatic checkOutput(input string name, input logic [255:0] actual, input logic [255:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    reset    = 1'b0;
    fillReq  = v.req;
    fillAddr = v.addr;
    memAck   = v.ack;
    memData  = v.data;
  endtask

  task automatic checkVector(input vec_t v, input int idx);
    checkOutput($sformatf("vec%0d_ready", idx), fillReady, v.expReady);
    checkOutput($sformatf("vec%0d_memReq", idx), memReq, v.expMemReq);
    if (v.chkAddr) checkOutput($sformatf("vec%0d_memAddr", idx), memAddr, v.expMemAddr);
    checkOutput($sformatf("vec%0d_we", idx), writeEnable, v.expWe);
    checkOutput($sformatf("vec%0d_done", idx), fillDone, v.expWe);
    checkOutput($sformatf("vec%0d_waddr", idx), writeAddress, v.expWaddr);
    checkOutput($sformatf("vec%0d_count", idx), fillCount, v.expCount);
    if (v.chkBlock) checkOutput($sformatf("vec%0d_block", idx), writeBlock, B2B_BLOCK);
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_ready"}, fillReady, 1'b1);
    checkOutput({tag, "_memReq"}, memReq, 1'b0);
    checkOutput({tag, "_memAddr"}, memAddr, 16'h0000);
    checkOutput({tag, "_we"}, writeEnable, 1'b0);
    checkOutput({tag, "_done"}, fillDone, 1'b0);
    checkOutput({tag, "_waddr"}, writeAddress, 16'h0000);
    checkOutput({tag, "_block"}, writeBlock, 256'h0);
    checkOutput({tag, "_count"}, fillCount, 16'h0000);
  endtask

  // One whole fill from IDLE. stall<0 draws 0..3 stall cycles per beat at random.
  // The model only knows the rules: beat k lives at {tag,k,000}, the block is the
  // beats concatenated, and the write lands 5 cycles after accept plus one per stall.
  task automatic runFill(input logic [15:0] addr, input int stall, input bit injectReq);
    logic [255:0] expBlock;
    logic [10:0]  tag;
    logic [63:0]  beat;
    int           stalls;
    int           acceptCyc;
    int           n;
    expBlock = '0;
    tag = addr[15:5];
    stalls = 0;
    fillReq = 1'b1;
    fillAddr = addr;
    memAck = 1'b0;
    checkOutput("ready_before_accept", fillReady, 1'b1);
    acceptCyc = cyc;
    tick();
    fillReq = injectReq;
    fillAddr = injectReq ? 16'h0040 : addr;
    for (int k = 0; k < 4; k++) begin
      n = (stall < 0) ? int'($urandom_range(0, 3)) : stall;
      for (int s = 0; s < n; s++) begin
        memAck = 1'b0;
        memData = {$urandom, $urandom};
        checkOutput("memReq_stall", memReq, 1'b1);
        checkOutput("memAddr_stall", memAddr, {tag, 2'(k), 3'b000});
        tick();
        stalls++;
      end
      beat = {$urandom, $urandom};
      expBlock[64*k +: 64] = beat;
      memAck = 1'b1;
      memData = beat;
      checkOutput("memReq_beat", memReq, 1'b1);
      checkOutput("memAddr_beat", memAddr, {tag, 2'(k), 3'b000});
      checkOutput("we_during_beat", writeEnable, 1'b0);
      tick();
    end
    memAck = 1'b0;
    fillReq = 1'b0;
    checkOutput("fill_we", writeEnable, 1'b1);
    checkOutput("fill_done", fillDone, 1'b1);
    checkOutput("fill_memReq_drop", memReq, 1'b0);
    checkOutput("fill_waddr", writeAddress, {tag, 5'b00000});
    checkOutput("fill_block", writeBlock, expBlock);
    checkOutput("fill_latency", 256'(cyc - acceptCyc), 256'(5 + stalls));
    checkOutput("fill_count_pre", fillCount, expCount);
    tick();
    expCount = expCount + 16'd1;
    checkOutput("after_ready", fillReady, 1'b1);
    checkOutput("after_we", writeEnable, 1'b0);
    checkOutput("after_count", fillCount, expCount);
    checkOutput("after_waddr_hold", writeAddress, {tag, 5'b00000});
    if (injectReq) begin
      tick();
      checkOutput("injected_req_not_queued", memReq, 1'b0);
    end
  endtask

  initial begin
    vecs[0] = mkVec(1'b1, 16'h1234, 1'b0, 64'h0,        1'b0, 1'b1, 1'b1, 16'h1220, 1'b0, 16'h0000, 16'd0, 1'b0);
    vecs[1] = mkVec(1'b0, 16'h0000, 1'b1, BEAT1,        1'b0, 1'b1, 1'b1, 16'h1228, 1'b0, 16'h0000, 16'd0, 1'b0);
    vecs[2] = mkVec(1'b0, 16'h0000, 1'b1, BEAT1 * 64'd2, 1'b0, 1'b1, 1'b1, 16'h1230, 1'b0, 16'h0000, 16'd0, 1'b0);
    vecs[3] = mkVec(1'b0, 16'h0000, 1'b1, BEAT1 * 64'd3, 1'b0, 1'b1, 1'b1, 16'h1238, 1'b0, 16'h0000, 16'd0, 1'b0);
    vecs[4] = mkVec(1'b0, 16'h0000, 1'b1, BEAT1 * 64'd4, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h1220, 16'd0, 1'b1);
    vecs[5] = mkVec(1'b0, 16'h0000, 1'b0, 64'h0,        1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h1220, 16'd1, 1'b1);
    vecs[6] = mkVec(1'b0, 16'h0000, 1'b1, 64'hDEAD_BEEF_DEAD_BEEF, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h1220, 16'd1, 1'b1);
    vecs[7] = mkVec(1'b0, 16'h0000, 1'b0, 64'h0,        1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h1220, 16'd1, 1'b1);

    reset = 1'b1;
    tick();
    tick();
    checkResetValues("reset");
    reset = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    checkResetValues("idle10");

    for (int i = 0; i < 8; i++) begin
      applyStimulus(vecs[i]);
      tick();
      checkVector(vecs[i], i);
    end
    expCount = 16'd1;

    runFill(16'h2345, 3, 1'b0);
    runFill(16'h0ABC, 0, 1'b1);

    // Abort a fill after beat 2 has been captured.
    fillReq = 1'b1;
    fillAddr = 16'h5678;
    tick();
    fillReq = 1'b0;
    for (int k = 0; k < 3; k++) begin
      memAck = 1'b1;
      memData = {$urandom, $urandom};
      tick();
    end
    memAck = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checkResetValues("midfill_reset");
    expCount = '0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("midfill_no_write", writeEnable, 1'b0);
    end
    runFill(16'h9ABC, -1, 1'b0);

    for (int i = 0; i < 20; i++) runFill(16'($urandom), -1, 1'b0);

    force dut.r_fillCount = 16'hFFFF;
    #1;
    release dut.r_fillCount;
    expCount = 16'hFFFF;
    checkOutput("count_preload", fillCount, 16'hFFFF);
    runFill(16'hFFE0, 0, 1'b0);
    checkOutput("count_wrapped", fillCount, 16'h0000);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
